// File: rtl/alu_issue_seq_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer.
//   - Default widths for the data path, register index and flag register.
//   - ALU opcode encodings recognised by the sequencer.
//   - Sequencer state encoding and the opcode-lookup result record.
package alu_issue_seq_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RA_W_DEF   = 4;
  localparam int FR_W_DEF   = 16;
  localparam int OP_W       = 6;
  localparam int CNT_W      = 3;

  // One-stage opcodes
  localparam logic [OP_W-1:0] OP_FLAGRST = 6'b000110;
  localparam logic [OP_W-1:0] OP_INCDEC  = 6'b100100;
  localparam logic [OP_W-1:0] OP_CMP     = 6'b010110;
  localparam logic [OP_W-1:0] OP_SHROT   = 6'b010000;
  // Two-stage opcodes
  localparam logic [OP_W-1:0] OP_ADD     = 6'b100000;
  localparam logic [OP_W-1:0] OP_MUL     = 6'b100010;
  localparam logic [OP_W-1:0] OP_DIV     = 6'b100011;
  localparam logic [OP_W-1:0] OP_MOD     = 6'b100101;
  localparam logic [OP_W-1:0] OP_AND     = 6'b010010;
  localparam logic [OP_W-1:0] OP_OR      = 6'b010011;
  localparam logic [OP_W-1:0] OP_XOR     = 6'b010100;
  localparam logic [OP_W-1:0] OP_NOT     = 6'b010101;
  localparam logic [OP_W-1:0] OP_ADD32   = 6'b011101;
  // Three-stage opcodes
  localparam logic [OP_W-1:0] OP_SUB     = 6'b100001;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_CAPT  = 3'd3,
    ST_WB    = 3'd4
  } state_t;

  // stages: ALU pipeline depth S; wr: result goes to the register file;
  // legal: opcode is one the ALU implements.
  typedef struct packed {
    logic [1:0] stages;
    logic       wr;
    logic       legal;
  } op_info_t;

endpackage

// File: rtl/alu_issue_seq_alu_op_lut.sv
// alu_op_lut: combinational opcode decoder. The single place where the list
// of ALU opcodes, their pipeline depth and their write-back behaviour lives.
// Ports:
//   op_i   [6]  opcode to classify
//   info_o      {stages, wr, legal}; unknown opcodes read as S=1, no write
module alu_op_lut
  import alu_issue_seq_pkg::*;
(
  input  logic [OP_W-1:0] op_i,
  output op_info_t        info_o
);

  always_comb begin
    info_o = '{stages: 2'd1, wr: 1'b0, legal: 1'b0};
    case (op_i)
      OP_FLAGRST, OP_CMP:
        info_o = '{stages: 2'd1, wr: 1'b0, legal: 1'b1};
      OP_INCDEC, OP_SHROT:
        info_o = '{stages: 2'd1, wr: 1'b1, legal: 1'b1};
      OP_ADD, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADD32:
        info_o = '{stages: 2'd2, wr: 1'b1, legal: 1'b1};
      OP_SUB:
        info_o = '{stages: 2'd3, wr: 1'b1, legal: 1'b1};
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: issue/writeback sequencer in front of the multi-stage ALU.
// Takes one instruction at a time, reads both operands from the register
// file, holds the ALU enabled for S+1 cycles with stable inputs, captures the
// ALU result and flags, writes the result back and owns the flag register.
//
// Optional feature macro: ALU_ISSUE_OPCHK_EN
//   defined   - unknown opcodes skip the ALU, pulse illegal_op with done,
//               no write and the flag register is left untouched.
//   undefined - unknown opcodes run as S=1 without write; illegal_op tied 0.
//
// Ports:
//   wire_clock / wire_reset           clock, async active-high reset
//   instr_valid / instr_ready         instruction handshake
//   instr_op/rd/ra/rb/carry/shf/dec   decoded instruction fields
//   rf_raddr_a/b, rf_rdata_a/b        register file read (combinational)
//   rf_we, rf_waddr, rf_wdata         register file write
//   enable_alu, m3, m4, opCode, FR_in,
//   useCarry, flagToShifthAndRot, dec ALU drive
//   m2, FR_out                        ALU result and flags
//   done                              one-cycle pulse at writeback
//   illegal_op                        one-cycle pulse for rejected opcodes
module alu_issue_seq
  import alu_issue_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RA_W   = RA_W_DEF,
  parameter int FR_W   = FR_W_DEF
) (
  input  logic              wire_clock,
  input  logic              wire_reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [RA_W-1:0]   instr_rd,
  input  logic [RA_W-1:0]   instr_ra,
  input  logic [RA_W-1:0]   instr_rb,
  input  logic              instr_carry,
  input  logic [2:0]        instr_shf,
  input  logic              instr_dec,
  output logic [RA_W-1:0]   rf_raddr_a,
  output logic [RA_W-1:0]   rf_raddr_b,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic              rf_we,
  output logic [RA_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              enable_alu,
  output logic [DATA_W-1:0] m3,
  output logic [DATA_W-1:0] m4,
  output logic [OP_W-1:0]   opCode,
  output logic [FR_W-1:0]   FR_in,
  output logic              useCarry,
  output logic [2:0]        flagToShifthAndRot,
  output logic              dec,
  input  logic [DATA_W-1:0] m2,
  input  logic [FR_W-1:0]   FR_out,
  output logic              done,
  output logic              illegal_op
);

  state_t            state_q;
  logic              ready_q;
  logic [OP_W-1:0]   op_q;
  logic [RA_W-1:0]   rd_q, ra_q, rb_q;
  logic              carry_q, dec_q;
  logic [2:0]        shf_q;
  logic [1:0]        stg_q;
  logic              wr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              en_q;
  logic [DATA_W-1:0] m3_q, m4_q;
  logic [DATA_W-1:0] result_q;
  logic [FR_W-1:0]   fr_q;
  logic              we_q, done_q;
  op_info_t          info;
  logic              accept;

  // Decode the incoming opcode so depth and write-enable are latched together
  // with the rest of the instruction at acceptance.
  alu_op_lut u_lut (
    .op_i   (instr_op),
    .info_o (info)
  );

  // ready_q is only ever high in IDLE
  assign accept = (state_q == ST_IDLE) && ready_q && instr_valid;

`ifdef ALU_ISSUE_OPCHK_EN
  logic ill_q;
  assign illegal_op = ill_q;
`else
  logic unused_legal;
  assign unused_legal = info.legal;
  assign illegal_op   = 1'b0;
`endif

  always_ff @(posedge wire_clock or posedge wire_reset) begin
    if (wire_reset) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b0;
      op_q     <= '0;
      rd_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      carry_q  <= 1'b0;
      shf_q    <= '0;
      dec_q    <= 1'b0;
      stg_q    <= '0;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      m3_q     <= '0;
      m4_q     <= '0;
      result_q <= '0;
      fr_q     <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_ISSUE_OPCHK_EN
      ill_q    <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; the states below raise them for one cycle.
      en_q   <= 1'b0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
`ifdef ALU_ISSUE_OPCHK_EN
      ill_q  <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            op_q    <= instr_op;
            rd_q    <= instr_rd;
            ra_q    <= instr_ra;
            rb_q    <= instr_rb;
            carry_q <= instr_carry;
            shf_q   <= instr_shf;
            dec_q   <= instr_dec;
            stg_q   <= info.stages;
            wr_q    <= info.wr;
`ifdef ALU_ISSUE_OPCHK_EN
            if (!info.legal) begin
              // Rejected opcode: bypass the ALU entirely.
              state_q <= ST_WB;
              done_q  <= 1'b1;
              ill_q   <= 1'b1;
            end else begin
              state_q <= ST_READ;
            end
`else
            state_q <= ST_READ;
`endif
          end else begin
            // Ready lags IDLE entry by one cycle, so enable_alu stays low
            // long enough for the ALU to see a fresh rising edge.
            ready_q <= 1'b1;
          end
        end

        ST_READ: begin
          m3_q    <= rf_rdata_a;
          m4_q    <= rf_rdata_b;
          cnt_q   <= {1'b0, stg_q} + CNT_W'(1);
          state_q <= ST_ISSUE;
        end

        ST_ISSUE: begin
          // enable_alu is registered, so it trails ISSUE by one cycle and
          // covers exactly S+1 cycles ending just before the capture edge.
          en_q  <= 1'b1;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_CAPT;
          end
        end

        ST_CAPT: begin
          result_q <= m2;
          fr_q     <= FR_out;
          we_q     <= wr_q;
          done_q   <= 1'b1;
          state_q  <= ST_WB;
        end

        ST_WB: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_ready        = ready_q;
  assign rf_raddr_a         = ra_q;
  assign rf_raddr_b         = rb_q;
  assign rf_we              = we_q;
  assign rf_waddr           = rd_q;
  assign rf_wdata           = result_q;
  assign enable_alu         = en_q;
  assign m3                 = m3_q;
  assign m4                 = m4_q;
  assign opCode             = op_q;
  assign FR_in              = fr_q;
  assign useCarry           = carry_q;
  assign flagToShifthAndRot = shf_q;
  assign dec                = dec_q;
  assign done               = done_q;

endmodule
